// File: rtl/dm_cache_if.sv
// CPU and memory-side signal bundle for dm_cache.
// The hit/miss counter signals exist only when CACHE_STATS_EN is defined.
interface dm_cache_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        inv;
  logic [15:0] rdata;
  logic        stall;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  modport slave (
    input  req, we, addr, wdata, inv, mem_rdata, mem_rvalid,
    output rdata, stall, mem_rd, mem_wr, mem_addr, mem_wdata
`ifdef CACHE_STATS_EN
    , output hit_cnt, miss_cnt
`endif
  );

  modport master (
    output req, we, addr, wdata, inv, mem_rdata, mem_rvalid,
    input  rdata, stall, mem_rd, mem_wr, mem_addr, mem_wdata
`ifdef CACHE_STATS_EN
    , input hit_cnt, miss_cnt
`endif
  );
endinterface

// File: rtl/dm_cache.sv
// Direct-mapped, write-through, no-write-allocate cache with a pipelined block fill.
// Define CACHE_STATS_EN to add saturating read hit/miss counters.
module dm_cache #(
  parameter int NUM_LINES       = 64,
  parameter int WORDS_PER_BLOCK = 8
) (
  input logic        clk,
  input logic        rst_n,
  dm_cache_if.slave  bus
);

  localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 15 - OFF_W - IDX_W;
  localparam logic [OFF_W:0] ISSUE_END = (OFF_W+1)'(WORDS_PER_BLOCK);

  typedef enum logic {IDLE, FILL} state_e;

  state_e               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [OFF_W:0]       issue_cnt_q, issue_cnt_d;
  logic [OFF_W-1:0]     ret_cnt_q, ret_cnt_d;
  logic                 inv_pend_q, inv_pend_d;

  logic [TAG_W-1:0] tag_mem  [NUM_LINES];
  logic [15:0]      data_mem [NUM_LINES][WORDS_PER_BLOCK];

  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic             line_hit;
  logic             rd_miss;
  logic             fill_last;
  logic             dwr_en;
  logic [OFF_W-1:0] dwr_off;
  logic [15:0]      dwr_val;
  logic             unused_addr_lsb;

  assign offset          = bus.addr[OFF_W:1];
  assign index           = bus.addr[OFF_W+IDX_W:OFF_W+1];
  assign tag             = bus.addr[15:OFF_W+IDX_W+1];
  assign unused_addr_lsb = bus.addr[0];

  assign line_hit  = valid_q[index] && (tag_mem[index] == tag);
  assign rd_miss   = (state_q == IDLE) && bus.req && !bus.we && !line_hit;
  assign fill_last = (state_q == FILL) && bus.mem_rvalid && (&ret_cnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      inv_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      inv_pend_q  <= inv_pend_d;
    end
  end

  // The line being filled is addressed by the held CPU request, so no copy of index/tag is kept.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    inv_pend_d  = inv_pend_q;
    case (state_q)
      IDLE: begin
        issue_cnt_d = '0;
        ret_cnt_d   = '0;
        inv_pend_d  = 1'b0;
        if (bus.inv) valid_d = '0;
        if (rd_miss) state_d = FILL;
      end
      FILL: begin
        if (issue_cnt_q != ISSUE_END) issue_cnt_d = issue_cnt_q + (OFF_W+1)'(1);
        if (bus.mem_rvalid) ret_cnt_d = ret_cnt_q + OFF_W'(1);
        if (bus.inv) inv_pend_d = 1'b1;
        if (fill_last) begin
          state_d    = IDLE;
          inv_pend_d = 1'b0;
          if (inv_pend_q || bus.inv) valid_d = '0;
          else                       valid_d[index] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.stall     = 1'b0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = {bus.addr[15:1], 1'b0};
    bus.mem_wdata = bus.wdata;
    case (state_q)
      IDLE: begin
        bus.stall  = rd_miss;
        bus.mem_wr = bus.req && bus.we;
      end
      FILL: begin
        bus.stall    = 1'b1;
        bus.mem_rd   = (issue_cnt_q != ISSUE_END);
        bus.mem_addr = {tag, index, issue_cnt_q[OFF_W-1:0], 1'b0};
      end
      default: ;
    endcase
    if (!rst_n) begin
      bus.stall  = 1'b0;
      bus.mem_rd = 1'b0;
      bus.mem_wr = 1'b0;
    end
  end

  assign bus.rdata = data_mem[index][offset];

  // Single data write port shared by write hits (IDLE) and fill returns (FILL).
  always_comb begin
    dwr_en  = 1'b0;
    dwr_off = offset;
    dwr_val = bus.wdata;
    if ((state_q == IDLE) && bus.req && bus.we && line_hit) begin
      dwr_en = 1'b1;
    end else if ((state_q == FILL) && bus.mem_rvalid) begin
      dwr_en  = 1'b1;
      dwr_off = ret_cnt_q;
      dwr_val = bus.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (dwr_en)    data_mem[index][dwr_off] <= dwr_val;
    if (fill_last) tag_mem[index]           <= tag;
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;
  logic        refilled_q, refilled_d;
  logic        rd_hit;

  assign rd_hit = (state_q == IDLE) && bus.req && !bus.we && line_hit;

  // The held request re-evaluated right after a fill is the same access, so it is not counted again.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    refilled_d = fill_last;
    if (rd_hit && !refilled_q && (hit_cnt_q != 16'hFFFF))
      hit_cnt_d = hit_cnt_q + 16'd1;
    if (rd_miss && !refilled_q && (miss_cnt_q != 16'hFFFF))
      miss_cnt_d = miss_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      refilled_q <= 1'b0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      refilled_q <= refilled_d;
    end
  end

  assign bus.hit_cnt  = hit_cnt_q;
  assign bus.miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dm_cache.sv
// Directed bench for dm_cache: vector table for single-cycle accesses plus
// hand-written fill, refill, invalidate and reset sequences against a latency-4 memory model.
module tb_dm_cache;

  localparam int LAT = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;

  dm_cache_if bus();

  dm_cache dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] a;
  } ret_t;

  ret_t        rq[$];
  logic [15:0] ram[int];

  function automatic logic [15:0] memVal(input logic [15:0] a);
    if (ram.exists(int'(a))) return ram[int'(a)];
    return a ^ 16'hC3C3;
  endfunction

  // Memory model: requests sampled mid-cycle, data returned LAT cycles later in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_rd) rq.push_back('{cyc + LAT, bus.mem_addr});
      if (bus.mem_wr) ram[int'(bus.mem_addr)] = bus.mem_wdata;
    end
  end

  always @(posedge clk) begin
    ret_t r;
    cyc = cyc + 1;
    #1;
    bus.mem_rvalid = 1'b0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      r = rq.pop_front();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = memVal(r.a);
    end
  end

  typedef struct {
    string       nm;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        inv;
    logic        exp_stall;
    logic        exp_wr;
    logic [15:0] exp_maddr;
    logic        chk_rd;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk); #1;
    bus.req   = 1'b1;
    bus.we    = v.we;
    bus.addr  = v.addr;
    bus.wdata = v.wdata;
    bus.inv   = v.inv;
    @(negedge clk);
    checkOutput({v.nm, " stall"}, 32'(bus.stall), 32'(v.exp_stall));
    checkOutput({v.nm, " mem_wr"}, 32'(bus.mem_wr), 32'(v.exp_wr));
    checkOutput({v.nm, " mem_rd"}, 32'(bus.mem_rd), 32'd0);
    if (v.exp_wr) begin
      checkOutput({v.nm, " mem_addr"}, 32'(bus.mem_addr), 32'(v.exp_maddr));
      checkOutput({v.nm, " mem_wdata"}, 32'(bus.mem_wdata), 32'(v.wdata));
    end
    if (v.chk_rd) checkOutput({v.nm, " rdata"}, 32'(bus.rdata), 32'(v.exp_rdata));
  endtask

  task automatic goIdle();
    @(posedge clk); #1;
    bus.req = 1'b0;
    bus.we  = 1'b0;
    bus.inv = 1'b0;
  endtask

  // Holds a read until stall drops, checking every fill beat; inv is pulsed on cycle inv_at.
  task automatic doRead(input logic [15:0] a, input logic [15:0] exp, input int exp_beats,
                        input int inv_at, input string nm);
    logic [2:0] bt;
    int   beats, runs, n;
    logic prev_rd, conflict, addr_bad, done, first_stall, first_rd;
    bt = '0; beats = 0; runs = 0; n = 0;
    prev_rd = 1'b0; conflict = 1'b0; addr_bad = 1'b0; done = 1'b0;
    first_stall = 1'b0; first_rd = 1'b0;
    @(posedge clk); #1;
    bus.req  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = a;
    bus.inv  = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      if (n == 0) begin
        first_stall = bus.stall;
        first_rd    = bus.mem_rd;
      end
      if (bus.mem_rd && bus.mem_wr) conflict = 1'b1;
      if (bus.mem_rd) begin
        if (!prev_rd) runs++;
        if (bus.mem_addr !== {a[15:4], bt, 1'b0}) addr_bad = 1'b1;
        bt++;
        beats++;
      end
      prev_rd = bus.mem_rd;
      if (!bus.stall) done = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
        bus.inv = (n == inv_at);
      end
    end
    bus.inv = 1'b0;
    if (exp_beats > 0) begin
      checkOutput({nm, " miss stall"}, 32'(first_stall), 32'd1);
      checkOutput({nm, " miss cycle mem_rd"}, 32'(first_rd), 32'd0);
    end else begin
      checkOutput({nm, " hit stall"}, 32'(first_stall), 32'd0);
    end
    checkOutput({nm, " completed"}, 32'(done), 32'd1);
    checkOutput({nm, " fill beats"}, 32'(beats), 32'(exp_beats));
    checkOutput({nm, " fill bursts"}, 32'(runs), 32'(exp_beats / 8));
    checkOutput({nm, " fill addr"}, 32'(addr_bad), 32'd0);
    checkOutput({nm, " rd/wr overlap"}, 32'(conflict), 32'd0);
    checkOutput({nm, " rdata"}, 32'(bus.rdata), 32'(exp));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int rets;
    int n;
    checks = 0;
    errors = 0;
    cyc    = 0;
    for (int i = 0; i < 8; i++) begin
      ram[16'h0040 + 2*i] = 16'hA000 + 16'(i);
      ram[16'h0440 + 2*i] = 16'hB000 + 16'(i);
    end

    vecs = '{
      '{"rd 0046",      1'b0, 16'h0046, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0046, 1'b1, 16'hA003},
      '{"rd 0047 odd",  1'b0, 16'h0047, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0046, 1'b1, 16'hA003},
      '{"rd 004E",      1'b0, 16'h004E, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h004E, 1'b1, 16'hA007},
      '{"wr 0042",      1'b1, 16'h0042, 16'h1234, 1'b0, 1'b0, 1'b1, 16'h0042, 1'b0, 16'h0000},
      '{"rd 0042",      1'b0, 16'h0042, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0042, 1'b1, 16'h1234},
      '{"wr miss 0843", 1'b1, 16'h0843, 16'h5555, 1'b0, 1'b0, 1'b1, 16'h0842, 1'b0, 16'h0000},
      '{"rd 0042 again",1'b0, 16'h0042, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0042, 1'b1, 16'h1234},
      '{"wr 004C",      1'b1, 16'h004C, 16'h0BEE, 1'b0, 1'b0, 1'b1, 16'h004C, 1'b0, 16'h0000},
      '{"rd 004C",      1'b0, 16'h004C, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h004C, 1'b1, 16'h0BEE},
      '{"rd 0040",      1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0040, 1'b1, 16'hA000},
      '{"rd 0040 inv",  1'b0, 16'h0040, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0040, 1'b1, 16'hA000}
    };

    rst_n          = 1'b0;
    bus.req        = 1'b0;
    bus.we         = 1'b0;
    bus.addr       = 16'h0000;
    bus.wdata      = 16'h0000;
    bus.inv        = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 16'h0000;

    // Reset state, including a pending request that must not raise stall or mem_wr.
    repeat (2) @(negedge clk);
    checkOutput("reset stall", 32'(bus.stall), 32'd0);
    checkOutput("reset mem_rd", 32'(bus.mem_rd), 32'd0);
    checkOutput("reset mem_wr", 32'(bus.mem_wr), 32'd0);
    bus.req = 1'b1; bus.addr = 16'h0040;
    #1;
    checkOutput("reset read stall", 32'(bus.stall), 32'd0);
    bus.we = 1'b1;
    #1;
    checkOutput("reset write mem_wr", 32'(bus.mem_wr), 32'd0);
`ifdef CACHE_STATS_EN
    checkOutput("reset hit_cnt", 32'(bus.hit_cnt), 32'd0);
    checkOutput("reset miss_cnt", 32'(bus.miss_cnt), 32'd0);
`endif
    bus.req = 1'b0; bus.we = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    doRead(16'h0040, 16'hA000, 8, -1, "cold 0040");
    for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);
    goIdle();

    doRead(16'h0040, 16'hA000, 8, -1, "post-inv 0040");
    doRead(16'h0440, 16'hB000, 8, -1, "conflict 0440");
    doRead(16'h0040, 16'hA000, 8, -1, "evicted 0040");
    doRead(16'h004C, 16'h0BEE, 0, -1, "wt 004C");
    doRead(16'h0042, 16'h1234, 0, -1, "wt 0042");
    doRead(16'h1080, 16'hD343, 16, 5, "inv mid-fill 1080");
    goIdle();

    // Reset right after the third return of a fill aborts it and leaves the line invalid.
    @(posedge clk); #1;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h2100;
    rets = 0; n = 0;
    while (rets < 3 && n < 50) begin
      @(negedge clk);
      if (bus.stall && bus.mem_rvalid) rets++;
      n++;
    end
    checkOutput("abort saw 3 returns", 32'(rets), 32'd3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort stall", 32'(bus.stall), 32'd0);
    checkOutput("abort mem_rd", 32'(bus.mem_rd), 32'd0);
    bus.req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    checkOutput("stale returns stall", 32'(bus.stall), 32'd0);
    doRead(16'h2100, 16'hE2C3, 8, -1, "after abort 2100");
    goIdle();
    @(negedge clk);
`ifdef CACHE_STATS_EN
    checkOutput("miss_cnt after abort", 32'(bus.miss_cnt), 32'd1);
    checkOutput("hit_cnt after abort", 32'(bus.hit_cnt), 32'd0);
`endif
    @(posedge clk); #1;
    bus.req = 1'b1; bus.addr = 16'h2104;
    @(negedge clk);
    checkOutput("hit 2104 stall", 32'(bus.stall), 32'd0);
    checkOutput("hit 2104 rdata", 32'(bus.rdata), 32'(16'h2104 ^ 16'hC3C3));
    goIdle();
    @(negedge clk);
`ifdef CACHE_STATS_EN
    checkOutput("hit_cnt after hit", 32'(bus.hit_cnt), 32'd1);
`endif
    checkOutput("idle mem_rd", 32'(bus.mem_rd), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
